// File: rtl/ahb_bm_input_stage.sv
// Master-side input stage of the AHB bus matrix. It requests the output-stage
// arbiter and holds an ungranted address phase while the master is stalled.
module ahb_bm_input_stage #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    output logic                  HREADYOUTS,
    output logic                  HRESPS,
    output logic                  req_o,
    output logic                  HSELI,
    output logic [ADDR_WIDTH-1:0] HADDRI,
    output logic [1:0]            HTRANSI,
    output logic                  HWRITEI,
    output logic [2:0]            HSIZEI,
    output logic [2:0]            HBURSTI,
    output logic [3:0]            HPROTI,
    output logic                  HMASTLOCKI,
    input  logic                  grant_i,
    input  logic                  HREADYM,
    input  logic                  HRESPM
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] haddr_q;
    logic [1:0]            htrans_q;
    logic                  hwrite_q;
    logic [2:0]            hsize_q;
    logic [2:0]            hburst_q;
    logic [3:0]            hprot_q;
    logic                  hmastlock_q;

    logic live_valid;
    logic taken;
    logic load;

    assign live_valid = HSELS & HREADYS & HTRANSS[1];
    assign taken      = grant_i & HREADYM;
    // PEND drives HREADYOUTS low, so the hold register is frozen there.
    assign load       = HSELS & HREADYS & (state_q != PEND);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= IDLE;
            haddr_q     <= '0;
            htrans_q    <= 2'b00;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b000;
            hburst_q    <= 3'b000;
            hprot_q     <= 4'b0000;
            hmastlock_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                haddr_q     <= HADDRS;
                htrans_q    <= HTRANSS;
                hwrite_q    <= HWRITES;
                hsize_q     <= HSIZES;
                hburst_q    <= HBURSTS;
                hprot_q     <= HPROTS;
                hmastlock_q <= HMASTLOCKS;
            end
        end
    end

    // Next state and master-facing response.
    always_comb begin
        state_d    = state_q;
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
        case (state_q)
            IDLE: begin
                if (live_valid) state_d = taken ? DATA : PEND;
            end
            PEND: begin
                HREADYOUTS = 1'b0;
                if (taken) state_d = DATA;
            end
            DATA: begin
                HREADYOUTS = HREADYM;
                HRESPS     = HRESPM;
                if (HREADYM) begin
                    if (live_valid) state_d = taken ? DATA : PEND;
                    else            state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Held phase replaces the live one only while pending.
    always_comb begin
        req_o = (state_q == PEND) | live_valid;
        if (state_q == PEND) begin
            HSELI      = 1'b1;
            HADDRI     = haddr_q;
            HTRANSI    = htrans_q;
            HWRITEI    = hwrite_q;
            HSIZEI     = hsize_q;
            HBURSTI    = hburst_q;
            HPROTI     = hprot_q;
            HMASTLOCKI = hmastlock_q;
        end else begin
            HSELI      = HSELS & HREADYS;
            HADDRI     = HADDRS;
            HTRANSI    = HTRANSS;
            HWRITEI    = HWRITES;
            HSIZEI     = HSIZES;
            HBURSTI    = HBURSTS;
            HPROTI     = HPROTS;
            HMASTLOCKI = HMASTLOCKS;
        end
    end

endmodule

// File: tb/tb_ahb_bm_input_stage.sv
// Directed bench for ahb_bm_input_stage; expectations are queued per cycle
// and compared on the falling edge.
module tb_ahb_bm_input_stage;

    localparam int unsigned AW = 32;

    logic          HCLK;
    logic          HRESET;
    logic          HSELS;
    logic [AW-1:0] HADDRS;
    logic [1:0]    HTRANSS;
    logic          HWRITES;
    logic [2:0]    HSIZES;
    logic [2:0]    HBURSTS;
    logic [3:0]    HPROTS;
    logic          HMASTLOCKS;
    logic          HREADYS;
    logic          HREADYOUTS;
    logic          HRESPS;
    logic          req_o;
    logic          HSELI;
    logic [AW-1:0] HADDRI;
    logic [1:0]    HTRANSI;
    logic          HWRITEI;
    logic [2:0]    HSIZEI;
    logic [2:0]    HBURSTI;
    logic [3:0]    HPROTI;
    logic          HMASTLOCKI;
    logic          grant_i;
    logic          HREADYM;
    logic          HRESPM;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Single-master bus: the master's HREADY is the ready this stage returns.
    assign HREADYS = HREADYOUTS;

    ahb_bm_input_stage #(.ADDR_WIDTH(AW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES),
        .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS),
        .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .req_o(req_o), .HSELI(HSELI), .HADDRI(HADDRI), .HTRANSI(HTRANSI),
        .HWRITEI(HWRITEI), .HSIZEI(HSIZEI), .HBURSTI(HBURSTI),
        .HPROTI(HPROTI), .HMASTLOCKI(HMASTLOCKI), .grant_i(grant_i),
        .HREADYM(HREADYM), .HRESPM(HRESPM)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic logic [31:0] obs(input string tag);
        case (tag)
            "rdy":   return 32'(HREADYOUTS);
            "resp":  return 32'(HRESPS);
            "req":   return 32'(req_o);
            "sel":   return 32'(HSELI);
            "addr":  return 32'(HADDRI);
            "trans": return 32'(HTRANSI);
            "write": return 32'(HWRITEI);
            "burst": return 32'(HBURSTI);
            "lock":  return 32'(HMASTLOCKI);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        q.push_back(e);
    endtask

    // Compare everything queued for this cycle, then advance past the edge.
    task automatic tick();
        exp_t        e;
        logic [31:0] o;
        @(negedge HCLK);
        while (q.size() > 0) begin
            e = q.pop_front();
            o = obs(e.tag);
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.tag, o, e.val);
            end
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans,
                         input logic [31:0] addr, input logic gnt,
                         input logic rdym, input logic respm);
        HSELS   = sel;
        HTRANSS = trans;
        HADDRS  = addr;
        grant_i = gnt;
        HREADYM = rdym;
        HRESPM  = respm;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        HRESET = 1'b1; HWRITES = 1'b0; HSIZES = 3'd2; HBURSTS = 3'd0;
        HPROTS = 4'h3; HMASTLOCKS = 1'b0;
        drive(1'b1, 2'b10, 32'h1000_0000, 1'b0, 1'b1, 1'b0);
        @(posedge HCLK); #1;

        // Reset with a live NONSEQ: req follows live inputs only.
        exp("rdy", 1); exp("resp", 0); exp("req", 1); exp("sel", 1);
        exp("addr", 32'h1000_0000);
        tick();

        HRESET = 1'b0;
        drive(1'b1, 2'b10, 32'h1000_0004, 1'b0, 1'b1, 1'b0);
        exp("req", 1); exp("rdy", 1); exp("addr", 32'h1000_0004);
        tick();

        // Reset while pending drops the held transfer.
        HRESET = 1'b1;
        drive(1'b0, 2'b00, 32'h0000_5555, 1'b0, 1'b1, 1'b0);
        exp("rdy", 0); exp("req", 1); exp("sel", 1); exp("addr", 32'h1000_0004);
        tick();
        HRESET = 1'b0;
        exp("rdy", 1); exp("req", 0); exp("sel", 0); exp("resp", 0);
        tick();

        // Granted single write: zero wait states.
        HWRITES = 1'b1;
        drive(1'b1, 2'b10, 32'h2000_0010, 1'b1, 1'b1, 1'b0);
        exp("addr", 32'h2000_0010); exp("req", 1); exp("rdy", 1);
        exp("sel", 1); exp("trans", 2); exp("write", 1);
        tick();
        HWRITES = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
        exp("rdy", 1); exp("resp", 0); exp("req", 0);
        tick();

        // Held INCR4 read with lock, three cycles without grant.
        HBURSTS = 3'd3; HMASTLOCKS = 1'b1;
        drive(1'b1, 2'b10, 32'h4000_0000, 1'b0, 1'b1, 1'b0);
        exp("req", 1); exp("rdy", 1); exp("addr", 32'h4000_0000);
        tick();
        HBURSTS = 3'd0; HMASTLOCKS = 1'b0;
        drive(1'b1, 2'b11, 32'h4000_0004, 1'b0, 1'b1, 1'b0);
        exp("req", 1); exp("rdy", 0); exp("addr", 32'h4000_0000);
        exp("trans", 2); exp("sel", 1); exp("lock", 1); exp("burst", 3);
        tick();
        drive(1'b1, 2'b11, 32'h4444_0000, 1'b0, 1'b1, 1'b0);
        exp("req", 1); exp("rdy", 0); exp("addr", 32'h4000_0000);
        tick();
        drive(1'b1, 2'b11, 32'h4444_0000, 1'b1, 1'b1, 1'b0);
        exp("req", 1); exp("rdy", 0); exp("addr", 32'h4000_0000);
        tick();

        // Slave wait states in the data phase.
        drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
        exp("rdy", 0); exp("resp", 0); exp("req", 0); exp("sel", 0);
        tick();
        exp("rdy", 0); exp("resp", 0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b0);
        exp("rdy", 1); exp("resp", 0);
        tick();

        // Two-cycle ERROR response passes through.
        drive(1'b1, 2'b10, 32'h6000_0000, 1'b1, 1'b1, 1'b0);
        exp("rdy", 1);
        tick();
        drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b1);
        exp("resp", 1); exp("rdy", 0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b1);
        exp("resp", 1); exp("rdy", 1);
        tick();
        exp("resp", 0); exp("rdy", 1);
        tick();

        // Back-to-back SEQ: granted goes straight through, ungranted is held.
        drive(1'b1, 2'b10, 32'h7000_0000, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 2'b11, 32'h7000_0004, 1'b1, 1'b1, 1'b0);
        exp("rdy", 1); exp("req", 1); exp("addr", 32'h7000_0004); exp("trans", 3);
        tick();
        drive(1'b1, 2'b11, 32'h7000_0008, 1'b0, 1'b1, 1'b0);
        exp("rdy", 1); exp("req", 1); exp("addr", 32'h7000_0008);
        tick();
        drive(1'b1, 2'b11, 32'h7000_000C, 1'b0, 1'b1, 1'b0);
        exp("rdy", 0); exp("trans", 3); exp("addr", 32'h7000_0008);
        exp("sel", 1); exp("req", 1);
        tick();
        // Grant without slave ready does not take the transfer.
        drive(1'b1, 2'b11, 32'h7000_000C, 1'b1, 1'b0, 1'b0);
        exp("rdy", 0); exp("addr", 32'h7000_0008);
        tick();
        drive(1'b1, 2'b11, 32'h7000_000C, 1'b1, 1'b1, 1'b0);
        exp("rdy", 0); exp("req", 1);
        tick();

        // BUSY is forwarded live but never requested or held.
        drive(1'b1, 2'b01, 32'h7000_000C, 1'b0, 1'b1, 1'b0);
        exp("rdy", 1); exp("req", 0); exp("sel", 1); exp("trans", 1);
        tick();
        drive(1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0);
        exp("rdy", 1); exp("req", 0); exp("resp", 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
